// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl
//   Power-up and recovery sequencer for the PLL. The sequencer holds the PLL in
//   reset, then waits for lock. It requires lock to stay stable before it
//   releases the downstream reset. When lock times out it retries, and after a
//   bounded number of retries it reports a hard failure. Everything runs on
//   i_sys_clk.
//
// Ports
//   i_sys_clk     system clock
//   i_sys_rst_n   synchronous active-low reset
//   i_pll_locked  PLL locked flag; asynchronous, so it is synchronized here
//   i_relock_req  single-cycle restart request; acted on in RUN and FAIL only
//   o_pll_areset  PLL reset, active-high
//   o_clk_rst_n   downstream reset, active-low; high only in RUN
//   o_clk_ready   high only in RUN
//   o_lock_err    high only in FAIL
//   o_retry_cnt   failed lock attempts in the current sequence
//   o_lost_cnt    lock-loss events seen in RUN; saturates at 255
module pll_lock_ctrl #(
  parameter int RST_HOLD_CYC     = 10,
  parameter int LOCK_STABLE_CYC  = 1000,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int MAX_RETRY        = 3
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst_n,
  input  logic       i_pll_locked,
  input  logic       i_relock_req,
  output logic       o_pll_areset,
  output logic       o_clk_rst_n,
  output logic       o_clk_ready,
  output logic       o_lock_err,
  output logic [1:0] o_retry_cnt,
  output logic [7:0] o_lost_cnt
);

  // The counter only has to reach (largest period - 1).
  localparam int CNT_MAX_AB = (RST_HOLD_CYC > LOCK_STABLE_CYC) ? RST_HOLD_CYC : LOCK_STABLE_CYC;
  localparam int CNT_MAX    = (CNT_MAX_AB > LOCK_TIMEOUT_CYC) ? CNT_MAX_AB : LOCK_TIMEOUT_CYC;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [1:0]       RETRY_LAST   = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sync1;
  logic             r_lock_s;
  logic [1:0]       r_retry_cnt;
  logic [7:0]       r_lost_cnt;
  logic             r_pll_areset;
  logic             r_clk_rst_n;
  logic             r_clk_ready;
  logic             r_lock_err;

  state_t           w_state_nxt;
  logic [1:0]       w_retry_nxt;
  logic             w_lost_inc;
  logic             w_state_chg;
  logic             w_counting;

  // Next-state, retry and lock-loss decode from the current state and the synchronized lock.
  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry_cnt;
    w_lost_inc  = 1'b0;
    case (r_state)
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) w_state_nxt = ST_WAIT;
        else                    w_state_nxt = ST_HOLD;
      end
      ST_WAIT: begin
        if (r_lock_s) begin
          w_state_nxt = ST_STABLE;
        end else if (r_cnt == TIMEOUT_LAST) begin
          if (r_retry_cnt == RETRY_LAST) begin
            w_state_nxt = ST_FAIL;
          end else begin
            w_retry_nxt = r_retry_cnt + 2'd1;
            w_state_nxt = ST_HOLD;
          end
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_STABLE: begin
        // A dropout during qualification restarts the lock wait, not the attempt.
        if (!r_lock_s) begin
          w_state_nxt = ST_WAIT;
        end else if (r_cnt == STABLE_LAST) begin
          w_state_nxt = ST_RUN;
          w_retry_nxt = 2'd0;
        end else begin
          w_state_nxt = ST_STABLE;
        end
      end
      ST_RUN: begin
        // Lock loss takes priority, so a simultaneous relock request is counted only once.
        if (!r_lock_s) begin
          w_state_nxt = ST_HOLD;
          w_lost_inc  = 1'b1;
        end else if (i_relock_req) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FAIL: begin
        if (i_relock_req) begin
          w_state_nxt = ST_HOLD;
          w_retry_nxt = 2'd0;
        end else begin
          w_state_nxt = ST_FAIL;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_retry_nxt = 2'd0;
      end
    endcase
  end

  assign w_state_chg = (w_state_nxt != r_state);
  assign w_counting  = (r_state == ST_HOLD) || (r_state == ST_WAIT) || (r_state == ST_STABLE);

  // Synchronizer, FSM state, counters and registered Moore outputs.
  // The outputs are decoded from the next state, so they change on the same edge as the state.
  always_ff @(posedge i_sys_clk) begin
    if (!i_sys_rst_n) begin
      r_sync1      <= 1'b0;
      r_lock_s     <= 1'b0;
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_retry_cnt  <= 2'd0;
      r_lost_cnt   <= 8'd0;
      r_pll_areset <= 1'b1;
      r_clk_rst_n  <= 1'b0;
      r_clk_ready  <= 1'b0;
      r_lock_err   <= 1'b0;
    end else begin
      r_sync1     <= i_pll_locked;
      r_lock_s    <= r_sync1;
      r_state     <= w_state_nxt;
      r_retry_cnt <= w_retry_nxt;
      if (w_state_chg)     r_cnt <= '0;
      else if (w_counting) r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      else                 r_cnt <= r_cnt;
      if (w_lost_inc && (r_lost_cnt != 8'hFF)) r_lost_cnt <= r_lost_cnt + 8'd1;
      else                                     r_lost_cnt <= r_lost_cnt;
      r_pll_areset <= (w_state_nxt == ST_HOLD) || (w_state_nxt == ST_FAIL);
      r_clk_rst_n  <= (w_state_nxt == ST_RUN);
      r_clk_ready  <= (w_state_nxt == ST_RUN);
      r_lock_err   <= (w_state_nxt == ST_FAIL);
    end
  end

  assign o_pll_areset = r_pll_areset;
  assign o_clk_rst_n  = r_clk_rst_n;
  assign o_clk_ready  = r_clk_ready;
  assign o_lock_err   = r_lock_err;
  assign o_retry_cnt  = r_retry_cnt;
  assign o_lost_cnt   = r_lost_cnt;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl
//   Directed bench for pll_lock_ctrl, using small timing parameters. Each table
//   record gives the inputs to drive for n cycles, and the outputs expected
//   after those cycles. Expected values are counted in edges after reset
//   release. Inputs are driven, and outputs sampled, on the falling edge.
module tb_pll_lock_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       relock;
  logic       o_pll_areset;
  logic       o_clk_rst_n;
  logic       o_clk_ready;
  logic       o_lock_err;
  logic [1:0] o_retry_cnt;
  logic [7:0] o_lost_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #10 clk = ~clk;

  pll_lock_ctrl #(
    .RST_HOLD_CYC     (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (32),
    .MAX_RETRY        (2)
  ) dut (
    .i_sys_clk    (clk),
    .i_sys_rst_n  (rst_n),
    .i_pll_locked (locked),
    .i_relock_req (relock),
    .o_pll_areset (o_pll_areset),
    .o_clk_rst_n  (o_clk_rst_n),
    .o_clk_ready  (o_clk_ready),
    .o_lock_err   (o_lock_err),
    .o_retry_cnt  (o_retry_cnt),
    .o_lost_cnt   (o_lost_cnt)
  );

  // Expected outputs are packed as {areset, clk_rst_n, ready, err, retry[1:0], lost[7:0]}.
  typedef struct {
    int          n;
    logic        rst_n;
    logic        locked;
    logic        relock;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic r, input logic l, input logic q,
                     input logic a, input logic c, input logic y, input logic e,
                     input logic [1:0] rc, input logic [7:0] lc);
    vec_t v;
    v.n      = n;
    v.rst_n  = r;
    v.locked = l;
    v.relock = q;
    v.exp    = {a, c, y, e, rc, lc};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [13:0] exp);
    logic [13:0] got;
    got = {o_pll_areset, o_clk_rst_n, o_clk_ready, o_lock_err, o_retry_cnt, o_lost_cnt};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got areset/rstn/ready/err/retry/lost=%b required %b at %0t",
               name, idx, got, exp, $time);
    end
  endtask

  initial begin
    int waited;
    rst_n  = 1'b0;
    locked = 1'b0;
    relock = 1'b0;
    repeat (10) @(negedge clk);
    check("reset", 0, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0});

    //   n   rst   lk    rq    area  rstn  rdy   err   retry lost          edge after release
    add(3,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);   // E3   HOLD
    add(1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);   // E4   WAIT
    add(4,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);   // E8   WAIT
    add(10,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);   // E18  STABLE
    add(1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);   // E19  RUN
    add(1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);   // E20  RUN
    add(1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0);   // E21  RUN
    add(1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);   // E22  HOLD, loss
    add(4,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);   // E26  WAIT
    add(8,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);   // E34  STABLE
    add(1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1);   // E35  RUN
    add(1,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);   // E36  HOLD by relock
    add(3,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);   // E39  HOLD
    add(1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);   // E40  WAIT
    add(5,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);   // E45  STABLE
    add(3,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);   // E48  back to WAIT
    add(10,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd1);   // E58  STABLE again
    add(1,   1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1);   // E59  RUN
    add(2,   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd1);   // E61  RUN
    add(1,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);   // E62  loss + relock
    add(1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);   // E63  HOLD, counted once
    add(3,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);   // E66  WAIT
    add(31,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);   // E97  last WAIT cycle
    add(1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd2);   // E98  timeout -> HOLD
    add(3,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 8'd2);   // E101 HOLD
    add(1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd2);   // E102 WAIT
    add(32,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, 8'd2);   // E134 timeout -> HOLD
    add(4,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd2);   // E138 WAIT
    add(31,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd2);   // E169 WAIT
    add(1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd2);   // E170 FAIL
    add(5,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd2);   // E175 FAIL
    add(1,   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);   // E176 relock -> HOLD
    add(4,   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);   // E180 relock ignored in HOLD
    add(4,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd2);   // E184 STABLE
    add(1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);   // E185 reset in STABLE
    add(3,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);   // E188 HOLD
    add(1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);   // E189 WAIT
    add(103, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0);   // E292 WAIT, third attempt
    add(1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd0);   // E293 FAIL
    add(1,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);   // E294 reset in FAIL
    add(1,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0);   // E295 HOLD

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n  = vecs[i].rst_n;
      locked = vecs[i].locked;
      relock = vecs[i].relock;
      @(negedge clk);
      relock = 1'b0;
      repeat (vecs[i].n - 1) @(negedge clk);
      check("vec", i, vecs[i].exp);
    end

    // Lock raised two cycles into HOLD: HOLD still runs its full length, so RUN is 12 edges away.
    locked = 1'b1;
    waited = 0;
    while (!o_clk_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_tests++;
    if (waited != 12) begin
      n_fail++;
      $display("FAIL lock_latency: got %0d cycles required 12", waited);
    end

    // Reset asserted in RUN: the released outputs drop on the next edge and stay down.
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("reset_in_run", k, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
